// File: rtl/vector_player.sv
// vector_player: plays a stimulus/expected vector table into a DUT, compares responses and counts mismatches; define VECTOR_PLAYER_STOP_ON_FAIL_EN to stop on the first mismatch
module vector_player #(
  parameter int IN_W     = 2,
  parameter int OUT_W    = 1,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [IN_W+OUT_W-1:0] load_data,
  input  logic [ADDR_W:0]       num_vec,
  input  logic                  start,
  output logic [IN_W-1:0]       stim,
  input  logic [OUT_W-1:0]      dut_resp,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     vec_idx,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic                  fail_valid,
  output logic [ADDR_W-1:0]     fail_idx
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam logic [ADDR_W:0] depth_n = (ADDR_W+1)'(DEPTH);
  localparam logic [HW-1:0] hold_last = HW'(HOLD_CYC - 1);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t                  state_q, state_d;
  logic [IN_W+OUT_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]         n_q, n_d;
  logic [ADDR_W-1:0]       vec_idx_q, vec_idx_d, fail_idx_q, fail_idx_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [IN_W-1:0]         stim_q, stim_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d, done_q, done_d, fail_valid_q, fail_valid_d;
  logic [IN_W+OUT_W-1:0]   first, cur, nxt;
  logic [ADDR_W:0]         n_sel;
  logic                    load_ok, mis, last_vec, stop;
  assign load_ok  = load_en && state_q != APPLY && {1'b0, load_addr} < depth_n;
  assign first    = (load_ok && load_addr == '0) ? load_data : mem[0];
  assign cur      = mem[vec_idx_q];
  assign nxt      = mem[vec_idx_q + 1'b1];
  assign n_sel    = num_vec > depth_n ? depth_n : num_vec;
  assign mis      = cur[OUT_W-1:0] != dut_resp;
  assign last_vec = {1'b0, vec_idx_q} == n_q - 1'b1;
`ifdef VECTOR_PLAYER_STOP_ON_FAIL_EN
  assign stop = last_vec || mis;
`else
  assign stop = last_vec;
`endif
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    vec_idx_d    = vec_idx_q;
    fail_idx_d   = fail_idx_q;
    hold_d       = hold_q;
    stim_d       = stim_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_valid_d = fail_valid_q;
    if (state_q != APPLY) begin
      if (start) begin
        n_d          = n_sel;
        cnt_d        = '0;
        fail_valid_d = 1'b0;
        fail_idx_d   = '0;
        done_d       = n_sel == '0;
        state_d      = n_sel == '0 ? DONE : APPLY;
        busy_d       = n_sel != '0;
        vec_idx_d    = n_sel == '0 ? vec_idx_q : '0;
        stim_d       = n_sel == '0 ? stim_q : first[IN_W+OUT_W-1:OUT_W];
        hold_d       = '0;
      end
    end else begin
      hold_d = hold_q + 1'b1;
      if (hold_q == hold_last) begin
        cnt_d        = (mis && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        fail_valid_d = fail_valid_q || mis;
        fail_idx_d   = (mis && !fail_valid_q) ? vec_idx_q : fail_idx_q;
        hold_d       = '0;
        state_d      = stop ? DONE : APPLY;
        busy_d       = !stop;
        done_d       = stop;
        vec_idx_d    = stop ? vec_idx_q : vec_idx_q + 1'b1;
        stim_d       = stop ? stim_q : nxt[IN_W+OUT_W-1:OUT_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      vec_idx_q    <= '0;
      fail_idx_q   <= '0;
      hold_q       <= '0;
      stim_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      vec_idx_q    <= vec_idx_d;
      fail_idx_q   <= fail_idx_d;
      hold_q       <= hold_d;
      stim_q       <= stim_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_valid_q <= fail_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr] <= load_data;
  end
  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vec_idx      = vec_idx_q;
  assign mismatch_cnt = cnt_q;
  assign fail_valid   = fail_valid_q;
  assign fail_idx     = fail_idx_q;
endmodule

// File: tb/tb_vector_player.sv
// tb_vector_player: table-driven and directed checks of vector_player against AND/OR/NAND DUT models
module tb_vector_player;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, load_en, start;
  logic [3:0] load_addr;
  logic [2:0] load_data;
  logic [4:0] num_vec;
  logic [1:0] stim, stim2;
  logic dut_resp, dut_resp2, busy, busy2, done, done2, fail_valid, fail_valid2;
  logic [3:0] vec_idx, vec_idx2, fail_idx, fail_idx2;
  logic [7:0] mismatch_cnt;
  logic [1:0] mismatch_cnt2;
  int mode = 0;
  int checks = 0, failures = 0;
`ifdef VECTOR_PLAYER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  function automatic logic resp_f(input int md, input logic [1:0] s);
    return md == 0 ? (s[1] & s[0]) : md == 1 ? (s[1] | s[0]) : ~(s[1] & s[0]);
  endfunction
  assign dut_resp  = resp_f(mode, stim);
  assign dut_resp2 = resp_f(mode, stim2);
  vector_player dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_vec(num_vec), .start(start), .stim(stim), .dut_resp(dut_resp), .busy(busy),
    .done(done), .vec_idx(vec_idx), .mismatch_cnt(mismatch_cnt), .fail_valid(fail_valid),
    .fail_idx(fail_idx)
  );
  vector_player #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_vec(num_vec), .start(start), .stim(stim2), .dut_resp(dut_resp2), .busy(busy2),
    .done(done2), .vec_idx(vec_idx2), .mismatch_cnt(mismatch_cnt2), .fail_valid(fail_valid2),
    .fail_idx(fail_idx2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(input logic [3:0] a, input logic [2:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic wait_done(inout int edges, inout bit saw_busy);
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
      saw_busy |= busy;
    end
  endtask
  task automatic run(input logic [4:0] nv, input int md, output int edges, output bit saw_busy);
    mode = md; num_vec = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    saw_busy = busy;
    wait_done(edges, saw_busy);
  endtask
  typedef struct {
    logic [4:0] nv;
    int md, cnt, fv, fidx, vidx, edges;
  } row_t;
  row_t rows[8];
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int e;
    bit sb;
    rows[0] = '{5'd4, 0, 0, 0, 0, 3, 9};
    rows[1] = STOP ? '{5'd4, 1, 1, 1, 1, 1, 5} : '{5'd4, 1, 2, 1, 1, 3, 9};
    rows[2] = '{5'd0, 1, 0, 0, 0, -1, 1};
    rows[3] = '{5'd31, 0, 0, 0, 0, 15, 33};
    rows[4] = STOP ? '{5'd16, 1, 1, 1, 1, 1, 5} : '{5'd16, 1, 8, 1, 1, 15, 33};
    rows[5] = STOP ? '{5'd3, 1, 1, 1, 1, 1, 5} : '{5'd3, 1, 2, 1, 1, 2, 7};
    rows[6] = '{5'd1, 1, 0, 0, 0, 0, 3};
    rows[7] = STOP ? '{5'd8, 2, 1, 1, 0, 0, 3} : '{5'd8, 2, 8, 1, 0, 7, 17};
    rst = 1'b1; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0; num_vec = '0;
    repeat (3) @(negedge clk);
    chk("rst_stim", 32'(stim), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_vec_idx", 32'(vec_idx), 0);
    chk("rst_cnt", 32'(mismatch_cnt), 0);
    chk("rst_fail_valid", 32'(fail_valid), 0);
    chk("rst_fail_idx", 32'(fail_idx), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] s;
      s = 2'(i);
      load(4'(i), {s, s[1] & s[0]});
    end
    mode = 0; num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("and_seq_stim_%0d", k), 32'(stim), 32'(k / 2));
      chk($sformatf("and_seq_busy_%0d", k), 32'(busy), 1);
      @(negedge clk);
    end
    chk("and_seq_done", 32'(done), 1);
    chk("and_seq_busy_end", 32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      run(rows[i].nv, rows[i].md, e, sb);
      chk($sformatf("row%0d_edges", i), 32'(e), 32'(rows[i].edges));
      chk($sformatf("row%0d_cnt", i), 32'(mismatch_cnt), 32'(rows[i].cnt));
      chk($sformatf("row%0d_fail_valid", i), 32'(fail_valid), 32'(rows[i].fv));
      chk($sformatf("row%0d_fail_idx", i), 32'(fail_idx), 32'(rows[i].fidx));
      chk($sformatf("row%0d_busy_seen", i), 32'(sb), 32'(rows[i].nv != 0));
      chk($sformatf("row%0d_busy_end", i), 32'(busy), 0);
      chk($sformatf("row%0d_cnt_sat", i), 32'(mismatch_cnt2), 32'(rows[i].cnt > 3 ? 3 : rows[i].cnt));
      chk($sformatf("row%0d_done_sat", i), 32'(done2), 1);
      if (rows[i].vidx >= 0) begin
        chk($sformatf("row%0d_vec_idx", i), 32'(vec_idx), 32'(rows[i].vidx));
        chk($sformatf("row%0d_stim", i), 32'(stim), 32'(rows[i].vidx % 4));
      end
    end
    mode = 0; num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; num_vec = 5'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_vec_idx", 32'(vec_idx), 1);
    chk("midstart_busy", 32'(busy), 1);
    repeat (5) @(negedge clk);
    chk("midstart_done", 32'(done), 1);
    chk("midstart_final_idx", 32'(vec_idx), 3);
    num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load(4'd2, 3'b110);
    e = 2; sb = 1'b1;
    wait_done(e, sb);
    run(5'd4, 0, e, sb);
    chk("midload_cnt", 32'(mismatch_cnt), 0);
    chk("midload_fail_valid", 32'(fail_valid), 0);
    num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_stim", 32'(stim), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_vec_idx", 32'(vec_idx), 0);
    chk("midrst_cnt", 32'(mismatch_cnt), 0);
    num_vec = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_vec_idx", 32'(vec_idx), 0);
    chk("rerun_busy", 32'(busy), 1);
    e = 1; sb = 1'b1;
    wait_done(e, sb);
    chk("rerun_edges", 32'(e), 9);
    chk("rerun_cnt", 32'(mismatch_cnt), 0);
    load_en = 1'b1; load_addr = 4'd0; load_data = 3'b010;
    num_vec = 5'd1; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    chk("loadstart_stim", 32'(stim), 1);
    e = 1; sb = 1'b1;
    wait_done(e, sb);
    chk("loadstart_edges", 32'(e), 3);
    chk("loadstart_cnt", 32'(mismatch_cnt), 0);
    load(4'd0, 3'b000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
